crc_frame_tx: RTL and testbench

Byte-to-bit frame serializer that sits directly upstream of the serial CCITT CRC unit. It accepts framed bytes over a valid/ready handshake and shifts them out MSB-first on a one-bit serial stream. It drives the CRC unit's enable, init and data inputs in lock-step with that stream, then appends the 16-bit CRC returned by the unit as the frame trailer.

---
 rtl/crc_pkg.sv | 21 ++
 rtl/crc_frame_tx.sv | 159 +++++++++++++++
 tb/tb_crc_frame_tx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the serial CCITT CRC frame path.
//   state_t  : frame serializer FSM states
//   CRC_W    : CRC width (16)
//   BYTE_W   : frame byte width (8)
//   CRC_SEED : value the CRC unit loads on init
package crc_pkg;

  localparam int CRC_W  = 16;
  localparam int BYTE_W = 8;

  localparam logic [CRC_W-1:0] CRC_SEED = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    DATA,
    CAPT,
    CRC
  } state_t;

endpackage

// File: rtl/crc_frame_tx.sv
// Byte-to-bit frame serializer feeding a serial CCITT CRC unit.
// Bytes arrive framed (sop/eop) and leave MSB-first on tx_bit. The CRC unit
// is driven in lock-step with the data bits, and its result is appended as a
// 16-bit trailer, MSB-first, with tx_last on the final trailer bit.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_data/sop/eop/valid   byte input, in_ready accepts it
//   tx_bit/valid/last       serial output, tx_ready consumes a bit
//   crc_en/init/bit         drive the CRC unit's enable/init/data_in
//   crc_value               CRC unit's current result
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. A producer holds its payload and valid until that cycle; ready may
// depend on valid (in_ready in IDLE does), valid never depends on ready.
module crc_frame_tx
  import crc_pkg::*;
#(
  parameter logic CRC_INVERT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_last,
  input  logic              tx_ready,
  output logic              crc_en,
  output logic              crc_init,
  output logic              crc_bit,
  input  logic [CRC_W-1:0]  crc_value
);

  state_t            state;
  state_t            state_nxt;
  logic [BYTE_W-1:0] sr;
  logic [3:0]        cnt;
  logic              eop_flag;
  logic [CRC_W-1:0]  csr;
  logic [3:0]        idx;

  // Datapath strobes produced alongside the FSM outputs.
  logic load;   // byte accepted into sr in DATA
  logic shift;  // a tx bit was consumed this cycle

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    tx_bit    = 1'b0;
    tx_valid  = 1'b0;
    tx_last   = 1'b0;
    crc_en    = 1'b0;
    crc_init  = 1'b0;
    crc_bit   = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_sop) begin
            // Leave the sop byte pending; DATA accepts it after INIT.
            state_nxt = INIT;
          end else begin
            // Stray byte outside a frame: swallow it to resynchronise.
            in_ready = 1'b1;
          end
        end
      end

      INIT: begin
        crc_en    = 1'b1;
        crc_init  = 1'b1;
        state_nxt = DATA;
      end

      DATA: begin
        if (cnt == 4'd0) begin
          in_ready = 1'b1;
          load     = in_valid;
        end else begin
          tx_valid = 1'b1;
          tx_bit   = sr[7];
          if (tx_ready) begin
            // One CRC enable per consumed bit; stalls issue none.
            shift   = 1'b1;
            crc_en  = 1'b1;
            crc_bit = sr[7];
            if (cnt == 4'd1 && eop_flag) begin
              state_nxt = CAPT;
            end
          end
        end
      end

      // Gap cycle so the CRC unit's update from the last data bit is
      // visible on crc_value before it is latched.
      CAPT: begin
        state_nxt = CRC;
      end

      CRC: begin
        tx_valid = 1'b1;
        tx_bit   = csr[15];
        tx_last  = (idx == 4'd0);
        shift    = tx_ready;
        if (tx_ready && idx == 4'd0) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      eop_flag <= 1'b0;
      csr      <= '0;
      idx      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        DATA: begin
          if (load) begin
            sr       <= in_data;
            cnt      <= 4'd8;
            eop_flag <= in_eop;
          end else if (shift) begin
            sr  <= {sr[6:0], 1'b0};
            cnt <= cnt - 4'd1;
          end
        end
        CAPT: begin
          csr <= CRC_INVERT ? ~crc_value : crc_value;
          idx <= 4'd15;
        end
        CRC: begin
          if (shift) begin
            csr <= {csr[14:0], 1'b0};
            idx <= idx - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_tx.sv
// Directed bench for crc_frame_tx. Two instances share all inputs: dut with
// a plain trailer and dut_inv with an inverted trailer. A bench-side serial
// CCITT CRC unit responds to dut's crc_en/crc_init/crc_bit; stub_mode
// replaces its result with a fixed constant.
module tb_crc_frame_tx;
  import crc_pkg::*;

  localparam logic [15:0] POLY  = 16'h1021;
  localparam logic [15:0] STUB  = 16'hA5C3;
  localparam int          LIMIT = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [7:0]  in_data;
  logic        in_sop, in_eop, in_valid, tx_ready;
  logic        in_ready, tx_bit, tx_valid, tx_last, crc_en, crc_init, crc_bit;
  logic        i_in_ready, i_tx_bit, i_tx_valid, i_tx_last, i_crc_en, i_crc_init, i_crc_bit;
  logic [15:0] crc_value;
  logic [15:0] crc_reg = 16'h0;
  logic        stub_mode;

  crc_frame_tx #(.CRC_INVERT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid),
    .in_ready(in_ready),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .crc_en(crc_en), .crc_init(crc_init), .crc_bit(crc_bit), .crc_value(crc_value)
  );

  crc_frame_tx #(.CRC_INVERT(1'b1)) dut_inv (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid),
    .in_ready(i_in_ready),
    .tx_bit(i_tx_bit), .tx_valid(i_tx_valid), .tx_last(i_tx_last), .tx_ready(tx_ready),
    .crc_en(i_crc_en), .crc_init(i_crc_init), .crc_bit(i_crc_bit), .crc_value(crc_value)
  );

  // ---------------- CRC unit model ----------------
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  function automatic logic [15:0] crc_model(input logic [63:0] data, input int nbits);
    logic [15:0] c;
    c = CRC_SEED;
    for (int i = nbits - 1; i >= 0; i--) c = crc_step(c, data[i]);
    return c;
  endfunction

  always @(posedge clk) begin
    if (crc_init)    crc_reg <= CRC_SEED;
    else if (crc_en) crc_reg <= crc_step(crc_reg, crc_bit);
  end

  assign crc_value = stub_mode ? STUB : crc_reg;

  // ---------------- tx_ready driver ----------------
  logic stall_mode = 1'b0;
  initial begin
    int ph;
    ph = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        tx_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        tx_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic bits_q[$];
  logic inv_q[$];
  logic last_q[$];
  int   en_cnt   = 0;
  int   init_cnt = 0;
  int   busy_viol = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) begin
        bits_q.push_back(tx_bit);
        last_q.push_back(tx_last);
      end
      if (i_tx_valid && tx_ready) inv_q.push_back(i_tx_bit);
      if (crc_en && !crc_init) en_cnt++;
      if (crc_init) init_cnt++;
      if (in_ready && (tx_valid || dut.state == CAPT)) busy_viol++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] to_vec(input logic q[$], input int from);
    logic [63:0] v;
    v = '0;
    for (int i = from; i < q.size(); i++) v = {v[62:0], q[i]};
    return v;
  endfunction

  function automatic logic [13:0] outs_vec();
    return {in_ready, tx_valid, tx_bit, tx_last, crc_en, crc_init, crc_bit,
            i_in_ready, i_tx_valid, i_tx_bit, i_tx_last, i_crc_en, i_crc_init, i_crc_bit};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    logic ok;
    ok = 1'b0;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_valid = 1'b1;
    for (int n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    check("byte_accepted", ok, 1'b1);
  endtask

  // Returns just after the edge that consumes the tx_last bit.
  task automatic wait_frame_end();
    logic found;
    found = 1'b0;
    for (int n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (tx_valid && tx_ready && tx_last) begin
        found = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    check("frame_end_seen", found, 1'b1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int b0, e0, i0, t0;
    logic [15:0] ca, cb;

    reset     = 1'b1;
    in_data   = 8'h00;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_valid  = 1'b0;
    stub_mode = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs_vec(), 14'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs_vec(), 14'h0);
    @(posedge clk);
    #1;

    // 1-byte frame, stubbed CRC, both trailer polarities.
    b0 = bits_q.size(); e0 = en_cnt; i0 = init_cnt; t0 = cyc;
    send_byte(8'h81, 1'b1, 1'b1);
    wait_frame_end();
    check("t1_frame_cycles", cyc - t0, 28);
    check("t1_nbits", bits_q.size() - b0, 24);
    check("t1_bits", to_vec(bits_q, b0), {8'h81, 16'hA5C3});
    check("t1_inv_bits", to_vec(inv_q, b0), {8'h81, 16'h5A3C});
    check("t1_last", to_vec(last_q, b0), 64'h1);
    check("t1_init_cycles", init_cnt - i0, 1);
    check("t1_en_cycles", en_cnt - e0, 8);

    // 2-byte frame with tx_ready stalls, real CRC.
    stub_mode = 1'b0;
    stall_mode = 1'b1;
    b0 = bits_q.size(); e0 = en_cnt;
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b0, 1'b1);
    wait_frame_end();
    stall_mode = 1'b0;
    ca = crc_model(64'h1234, 16);
    check("t2_nbits", bits_q.size() - b0, 32);
    check("t2_bits", to_vec(bits_q, b0), {16'h1234, ca});
    check("t2_inv_bits", to_vec(inv_q, b0), {16'h1234, ~ca});
    check("t2_unit_crc", crc_reg, ca);
    check("t2_en_cycles", en_cnt - e0, 16);
    check("t2_last", to_vec(last_q, b0), 64'h1);

    // Back-to-back frames with a stray non-sop byte in between.
    b0 = bits_q.size(); i0 = init_cnt;
    send_byte(8'hAB, 1'b1, 1'b1);
    wait_frame_end();
    send_byte(8'h55, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t3_stray_silent", bits_q.size() - b0, 24);
    check("t3_stray_no_init", init_cnt - i0, 1);
    send_byte(8'h0F, 1'b1, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b1);
    wait_frame_end();
    ca = crc_model(64'hAB, 8);
    cb = crc_model(64'h0FF0, 16);
    check("t3_bits", to_vec(bits_q, b0), {8'hAB, ca, 16'h0FF0, cb});
    check("t3_init_cycles", init_cnt - i0, 2);

    // Reset during byte 2 of a 4-byte frame, then a fresh 1-byte frame.
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t4_reset_outputs", outs_vec(), 14'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    b0 = bits_q.size(); e0 = en_cnt;
    send_byte(8'h00, 1'b1, 1'b1);
    wait_frame_end();
    check("t4_bits", to_vec(bits_q, b0), {8'h00, crc_model(64'h00, 8)});
    check("t4_en_cycles", en_cnt - e0, 8);

    // Next sop held valid through DATA/CAPT/CRC must wait for IDLE.
    b0 = bits_q.size(); t0 = cyc;
    send_byte(8'hC3, 1'b1, 1'b1);
    send_byte(8'h5A, 1'b1, 1'b1);
    check("t5_accept_cycle", cyc - t0, 31);
    wait_frame_end();
    check("t5_bits", to_vec(bits_q, b0),
          {8'hC3, crc_model(64'hC3, 8), 8'h5A, crc_model(64'h5A, 8)});

    check("in_ready_while_busy", busy_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
